adc128s022_responder: RTL and testbench

- Synthesizable model of the ADC128S022 target side of the serial sensor interface.
- Takes the existing ADC controller's chip select, clock and address outputs and returns 12-bit samples on the data line.
- Per-channel sample values come from a parallel input bus.
- Used for FPGA loopback of the line-sensor path without the physical chip, and as the bench responder for the ADC controller.

---
 rtl/sb3320_adc_pkg.sv | 22 ++
 rtl/adc128s022_responder_sync_edge_detect.sv | 32 +++
 rtl/adc128s022_responder.sv | 142 ++++++++++++++
 tb/tb_adc128s022_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sb3320_adc_pkg.sv
// Shared constants and state encoding for the ADC128S022 serial link.
// Both the controller and the responder side import this package.
package sb3320_adc_pkg;

  localparam int FRAME_BITS      = 16;
  localparam int ADDR_FIRST_EDGE = 3;
  localparam int ADDR_BITS       = 3;
  localparam int DEF_DATA_W      = 12;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } adc_state_e;

  // True when the pre-increment rising-edge count selects an address bit.
  function automatic logic is_addr_edge(input logic [3:0] cnt);
    int c;
    c = int'(cnt);
    return (c >= ADDR_FIRST_EDGE - 1) && (c <= ADDR_FIRST_EDGE + ADDR_BITS - 2);
  endfunction

endpackage

// File: rtl/adc128s022_responder_sync_edge_detect.sv
// Multi-flop synchronizer followed by one history register that yields
// single-cycle rise/fall pulses aligned with the synchronized level.
module sync_edge_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adc128s022_responder.sv
// ADC128S022 target-side model: captures the channel address from din and
// shifts a frozen 16-bit sample frame out on dout, MSB first.
module adc128s022_responder
  import sb3320_adc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_CH      = 8
) (
  input  logic                       clk_50,
  input  logic                       reset,
  input  logic                       adc_cs_n,
  input  logic                       adc_sck,
  input  logic                       din,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic                       dout,
  output logic                       frame_done,
  output logic [ADDR_BITS-1:0]       rx_addr,
  output logic [ADDR_BITS-1:0]       conv_ch,
  output logic                       frame_err
);

  localparam int         PAD_W    = FRAME_BITS - DATA_W;
  localparam logic [3:0] LAST_CNT = 4'(FRAME_BITS - 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic din_s, din_rise, din_fall;
  logic sync_unused;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk_50), .reset(reset), .d_i(adc_cs_n),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sck_sync (
    .clk(clk_50), .reset(reset), .d_i(adc_sck),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_din_sync (
    .clk(clk_50), .reset(reset), .d_i(din),
    .level_o(din_s), .rise_o(din_rise), .fall_o(din_fall)
  );

  assign sync_unused = ^{cs_lvl, sck_lvl, din_rise, din_fall};

  logic [DATA_W-1:0] ch_arr [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
  end

  adc_state_e            state_q;
  logic [3:0]            bit_cnt_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [ADDR_BITS-1:0]  addr_sh_q;
  logic [ADDR_BITS-1:0]  next_ch_q;
  logic [ADDR_BITS-1:0]  conv_ch_q;
  logic [ADDR_BITS-1:0]  rx_addr_q;
  logic                  reload_q;
  logic                  dout_q;
  logic                  frame_done_q;
  logic                  frame_err_q;
  logic [FRAME_BITS-1:0] frame_word;

  assign frame_word = {{PAD_W{1'b0}}, ch_arr[next_ch_q]};

  // The falling edge that precedes the first rising edge of a frame holds
  // bit 15, or loads the next frame when a continuous frame just wrapped.
  always_ff @(posedge clk_50) begin
    // NOTE: pulse outputs default low here; a later non-blocking assignment
    // in the same pass overrides this, so no separate clear logic is needed.
    frame_done_q <= 1'b0;
    frame_err_q  <= 1'b0;
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_sh_q <= '0;
      next_ch_q <= '0;
      conv_ch_q <= '0;
      rx_addr_q <= '0;
      reload_q  <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dout_q    <= 1'b0;
          bit_cnt_q <= '0;
          reload_q  <= 1'b0;
          if (cs_fall) begin
            conv_ch_q <= next_ch_q;
            shift_q   <= frame_word;
            dout_q    <= frame_word[FRAME_BITS-1];
            state_q   <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state_q   <= ST_IDLE;
            dout_q    <= 1'b0;
            bit_cnt_q <= '0;
            reload_q  <= 1'b0;
            addr_sh_q <= '0;
            if (bit_cnt_q != 4'd0) frame_err_q <= 1'b1;
          end else if (sck_rise) begin
            if (is_addr_edge(bit_cnt_q))
              addr_sh_q <= {addr_sh_q[ADDR_BITS-2:0], din_s};
            if (bit_cnt_q == LAST_CNT) begin
              frame_done_q <= 1'b1;
              rx_addr_q    <= addr_sh_q;
              next_ch_q    <= addr_sh_q;
              bit_cnt_q    <= '0;
              reload_q     <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else if (sck_fall) begin
            if (bit_cnt_q != 4'd0) begin
              shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
              dout_q  <= shift_q[FRAME_BITS-2];
            end else if (reload_q) begin
              conv_ch_q <= next_ch_q;
              shift_q   <= frame_word;
              dout_q    <= frame_word[FRAME_BITS-1];
              reload_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign frame_done = frame_done_q;
  assign rx_addr    = rx_addr_q;
  assign conv_ch    = conv_ch_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_adc128s022_responder.sv
// Directed bench: drives CS/SCK/DIN like the ADC controller and compares
// the returned frames, channel selection and pulse counts to fixed values.
module tb_adc128s022_responder;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic        adc_cs_n;
  logic        adc_sck;
  logic        din;
  logic [95:0] ch_data;
  logic        dout;
  logic        frame_done;
  logic [2:0]  rx_addr;
  logic [2:0]  conv_ch;
  logic        frame_err;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;

  always #10 clk_50 = ~clk_50;

  adc128s022_responder dut (
    .clk_50(clk_50), .reset(reset), .adc_cs_n(adc_cs_n), .adc_sck(adc_sck),
    .din(din), .ch_data(ch_data), .dout(dout), .frame_done(frame_done),
    .rx_addr(rx_addr), .conv_ch(conv_ch), .frame_err(frame_err)
  );

  always @(negedge clk_50) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (10) @(negedge clk_50);
  endtask

  task automatic set_ch(input int k, input logic [11:0] v);
    ch_data[k*12 +: 12] = v;
  endtask

  // nbits SCK cycles with CS untouched; address goes out on bits 3..5,
  // every other din bit is driven high to show it is ignored.
  task automatic do_bits(input logic [2:0] addr, input int nbits, input int poke_at,
                         output logic [15:0] bits, output logic [2:0] conv);
    bits = '0;
    conv = '0;
    for (int k = 1; k <= nbits; k++) begin
      adc_sck = 1'b0;
      din = (k >= 3 && k <= 5) ? addr[5-k] : 1'b1;
      if (k == poke_at) set_ch(3, 12'hFFF);
      half();
      adc_sck = 1'b1;
      half();
      bits = {bits[14:0], dout};
      if (k == 1) conv = conv_ch;
    end
  endtask

  task automatic full_frame(input logic [2:0] addr, input int poke_at,
                            output logic [15:0] bits, output logic [2:0] conv);
    adc_cs_n = 1'b0;
    half();
    do_bits(addr, 16, poke_at, bits, conv);
    adc_cs_n = 1'b1;
    half();
  endtask

  initial begin
    logic [15:0] bits;
    logic [2:0]  conv;
    int          d0, e0;

    reset    = 1'b1;
    adc_cs_n = 1'b1;
    adc_sck  = 1'b1;
    din      = 1'b0;
    ch_data  = '0;
    set_ch(0, 12'hA5C);
    set_ch(1, 12'h9C3);
    set_ch(2, 12'h2B7);
    set_ch(3, 12'h111);
    set_ch(4, 12'h456);
    set_ch(5, 12'h3F1);
    set_ch(6, 12'h6A6);
    set_ch(7, 12'h7E4);
    repeat (3) @(negedge clk_50);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_rx_addr", 32'(rx_addr), 32'd0);
    check("rst_conv_ch", 32'(conv_ch), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    half();

    // First frame after reset converts channel 0.
    d0 = done_cnt; e0 = err_cnt;
    full_frame(3'd0, 0, bits, conv);
    check("f1_bits", 32'(bits), 32'h0A5C);
    check("f1_conv", 32'(conv), 32'd0);
    check("f1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("f1_rx_addr", 32'(rx_addr), 32'd0);
    check("f1_err_cnt", 32'(err_cnt - e0), 32'd0);
    check("idle_dout", 32'(dout), 32'd0);

    // Address channel 5, then see it converted in the following frame.
    full_frame(3'd5, 0, bits, conv);
    check("f2_bits", 32'(bits), 32'h0A5C);
    check("f2_rx_addr", 32'(rx_addr), 32'd5);
    full_frame(3'd0, 0, bits, conv);
    check("f3_conv", 32'(conv), 32'd5);
    check("f3_bits", 32'(bits), 32'h03F1);

    // Three back-to-back frames under one CS low period.
    d0 = done_cnt;
    adc_cs_n = 1'b0;
    half();
    do_bits(3'd2, 16, 0, bits, conv);
    check("bb1_conv", 32'(conv), 32'd0);
    check("bb1_bits", 32'(bits), 32'h0A5C);
    do_bits(3'd7, 16, 0, bits, conv);
    check("bb2_conv", 32'(conv), 32'd2);
    check("bb2_bits", 32'(bits), 32'h02B7);
    do_bits(3'd1, 16, 0, bits, conv);
    check("bb3_conv", 32'(conv), 32'd7);
    check("bb3_bits", 32'(bits), 32'h07E4);
    adc_cs_n = 1'b1;
    half();
    check("bb_done_cnt", 32'(done_cnt - d0), 32'd3);
    check("bb_rx_addr", 32'(rx_addr), 32'd1);

    // CS raised after 9 rising edges: error, address 4 discarded.
    d0 = done_cnt; e0 = err_cnt;
    adc_cs_n = 1'b0;
    half();
    do_bits(3'd4, 9, 0, bits, conv);
    adc_cs_n = 1'b1;
    half();
    check("abort_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("abort_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_rx_addr", 32'(rx_addr), 32'd1);
    full_frame(3'd3, 0, bits, conv);
    check("post_abort_conv", 32'(conv), 32'd1);
    check("post_abort_bits", 32'(bits), 32'h09C3);

    // Sample is frozen at frame load; the change shows up next frame.
    full_frame(3'd3, 8, bits, conv);
    check("freeze_conv", 32'(conv), 32'd3);
    check("freeze_bits", 32'(bits), 32'h0111);
    full_frame(3'd3, 0, bits, conv);
    check("refresh_conv", 32'(conv), 32'd3);
    check("refresh_bits", 32'(bits), 32'h0FFF);

    // Reset in the middle of bit 6 of a channel-3 frame.
    e0 = err_cnt;
    adc_cs_n = 1'b0;
    half();
    do_bits(3'd6, 6, 0, bits, conv);
    check("pre_rst_conv", 32'(conv), 32'd3);
    reset    = 1'b1;
    adc_cs_n = 1'b1;
    adc_sck  = 1'b1;
    @(negedge clk_50);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_done", 32'(frame_done), 32'd0);
    check("mid_rst_rx_addr", 32'(rx_addr), 32'd0);
    check("mid_rst_conv_ch", 32'(conv_ch), 32'd0);
    check("mid_rst_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    half();
    full_frame(3'd0, 0, bits, conv);
    check("post_rst_conv", 32'(conv), 32'd0);
    check("post_rst_bits", 32'(bits), 32'h0A5C);
    check("post_rst_err_cnt", 32'(err_cnt - e0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
